vector_data_memory: RTL
=======================

# vector_data_memory

Memory-side responder for the 256-bit vector data port. It accepts single-cycle read/write requests from the vector load/store unit with per-byte enables and returns read data exactly one cycle later. It also provides a byte-wide host port with a req/ack handshake, used for loading and dumping memory images. The processor port always has priority; host accesses only use idle processor cycles.

## Interface
Parameters:
- ADDR_W, 14, word-address width (one word = 256 bits = 32 bytes)
- DEPTH, 4096, number of implemented 256-bit words; valid word addresses are 0..DEPTH-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rden  in  1  processor read request, one cycle
- wren  in  1  processor write request, one cycle
- ip_address  in  ADDR_W  processor word address
- byteena  in  32  per-byte write enable; bit i controls writeData[8i+7:8i]
- writeData  in  256  processor write data
- readData  out  256  processor read data, registered
- host_req  in  1  host request; level, held until host_ack
- host_we  in  1  host op: 1 = write, 0 = read
- host_addr  in  ADDR_W+5  host byte address (word = [ADDR_W+4:5], byte lane = [4:0])
- host_wdata  in  8  host write byte
- host_rdata  out  8  host read byte, registered
- host_ack  out  1  one-cycle completion pulse
- host_busy  out  1  high while the host FSM is not IDLE

## Operation
- Storage: DEPTH x 256 bits. Contents are not cleared by reset.
- Processor write (wren=1):
  - Lanes with byteena[i]=1 are updated at the clock edge.
  - Lanes with byteena[i]=0 are unchanged.
  - byteena=0 is a legal no-op.
- Processor read (rden=1):
  - At the clock edge, readData <= word[ip_address].
  - readData holds its value in every cycle where rden=0.
- rden and wren together on the same address: read-first. readData gets the pre-write contents, and the write is still performed.
- Out of range (address >= DEPTH):
  - Writes are dropped.
  - Reads load 0.
- Host FSM, states IDLE, WAIT, HRD, ACK:
  - IDLE: if host_req=1, latch host_we, host_addr and host_wdata, then go to WAIT.
  - WAIT: if rden|wren is high this cycle, stay in WAIT (processor priority). Otherwise perform the host op in this cycle:
    - Write: byte lane host_addr[4:0] of the word gets host_wdata; all other lanes are unchanged. Next state ACK.
    - Read: the word is captured into an internal register. Next state HRD.
  - HRD: host_rdata <= lane host_addr[4:0] of the captured word (0 if out of range). Next state ACK.
  - ACK: host_ack=1 for exactly this cycle, then go to IDLE.
- The host must deassert host_req in the cycle after the ack. If host_req is still high in IDLE, that starts a new transaction.
- Host accesses never change readData.
- Out-of-range host accesses are still acked: writes are dropped and reads return 0.
- host_busy = (state != IDLE).
- There is no starvation guarantee. The host waits in WAIT as long as the processor issues back-to-back accesses.

## Timing
- Reset values: readData=0, host_rdata=0, host_ack=0, host_busy=0, FSM=IDLE.
- While reset=1:
  - Processor and host writes are suppressed.
  - Any in-flight host transaction is abandoned with no ack.
  - Memory contents are retained.
- Processor read latency: rden in cycle T gives valid readData in cycle T+1. This matches the load/store unit, which consumes data one cycle after the request, including two-beat unaligned accesses on consecutive addresses.
- Processor write: visible to a read issued in the next cycle (T+1 read returns the new data in T+2).
- Back-to-back processor accesses are accepted every cycle. There is no stall output.
- Host write, no contention: req sampled in T0 (IDLE), performed in T1 (WAIT), host_ack in T2.
- Host read, no contention: req in T0, word read in T1, byte captured in T2 (HRD), host_ack in T3 with host_rdata valid.
- Each processor-busy cycle in WAIT adds one cycle of host latency.
- A host write in WAIT and a processor read in the following cycle to the same word: the processor sees the host byte.

## Test plan
- Reset then idle:
  - Required: readData=0, host_ack=0, host_busy=0.
  - Hold rden=0 for 5 cycles after a read of a nonzero word; readData must hold.
- Byte-enable write:
  - Write addr 7 with all-ones data, byteena=FFFF_FFFF.
  - Then write 256'h0 with byteena=0000_000F.
  - Read addr 7 -> readData = all ones with bytes 0..3 = 00.
- Back-to-back:
  - Write addr 10 in cycle T, read 10 in T+1, read 11 in T+2.
  - Required: readData in T+2 = new word 10; in T+3 = word 11.
  - Same-cycle rden+wren to addr 3 returns the old value.
- Host round trip:
  - Host write byte 8'hA5 to byte address (5<<5)+17, then host read of the same address.
  - Required: acks in T2 and T3 respectively, host_rdata=A5.
  - A processor read of word 5 shows byte 17 = A5 with other bytes unchanged.
- Contention:
  - Host read issued while processor asserts rden for 4 consecutive cycles.
  - Required: host_ack delayed by exactly 4 cycles versus the uncontended case; readData unaffected.
- Reset mid-transaction and out of range:
  - Assert reset while FSM is in WAIT (host write pending) -> no ack, byte not written.
  - Processor read of address DEPTH -> readData=0.
  - Host read of word DEPTH -> ack with host_rdata=0.

Source files
------------

// File: rtl/vector_data_memory.sv
// Memory-side responder for the 256-bit vector data port, with a byte-wide
// host port that borrows idle processor cycles for image load/dump.
//
// state | meaning
// IDLE  | no host transaction; a host_req latches op, address and data
// WAIT  | host op pending; performed in the first cycle with rden=wren=0
// HRD   | captured word is narrowed to the requested byte lane
// ACK   | host_ack pulse, back to IDLE
module vector_data_memory #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rden,
  input  logic              wren,
  input  logic [ADDR_W-1:0] ip_address,
  input  logic [31:0]       byteena,
  input  logic [255:0]      writeData,
  output logic [255:0]      readData,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W+4:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  output logic              host_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HRD, S_ACK} state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [ADDR_W+4:0] addr_q;
  logic [7:0]        wdata_q;
  logic [255:0]      hword_q;
  logic [7:0]        rdata_q;
  logic [255:0]      rd_q;
  logic [255:0]      mem [0:DEPTH-1];

  logic              proc_busy;
  logic              p_in_range;
  logic              h_in_range;
  logic [IDX_W-1:0]  p_idx;
  logic [IDX_W-1:0]  h_idx;
  logic [ADDR_W-1:0] h_word;
  logic [4:0]        h_lane;
  logic              host_do_wr;
  logic              host_do_rd;

  assign proc_busy  = rden | wren;
  assign h_word     = addr_q[ADDR_W+4:5];
  assign h_lane     = addr_q[4:0];
  assign p_in_range = ({1'b0, ip_address} < DEPTH_W);
  assign h_in_range = ({1'b0, h_word} < DEPTH_W);
  assign p_idx      = ip_address[IDX_W-1:0];
  assign h_idx      = h_word[IDX_W-1:0];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (host_req) state_d = S_WAIT;
      S_WAIT: if (!proc_busy) state_d = we_q ? S_ACK : S_HRD;
      S_HRD:  state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    host_busy  = (state_q != S_IDLE);
    host_ack   = (state_q == S_ACK);
    host_do_wr = (state_q == S_WAIT) && !proc_busy && we_q;
    host_do_rd = (state_q == S_WAIT) && !proc_busy && !we_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && host_req) begin
      we_q    <= host_we;
      addr_q  <= host_addr;
      wdata_q <= host_wdata;
    end
  end

  // Host writes only ever fire in processor-idle cycles, so the two write
  // paths never collide on the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wren && p_in_range) begin
        for (int i = 0; i < 32; i++) begin
          if (byteena[i]) mem[p_idx][8*i +: 8] <= writeData[8*i +: 8];
        end
      end else if (host_do_wr && h_in_range) begin
        mem[h_idx][{h_lane, 3'b000} +: 8] <= wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (host_do_rd) hword_q <= h_in_range ? mem[h_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)                  rdata_q <= '0;
    else if (state_q == S_HRD)  rdata_q <= hword_q[{h_lane, 3'b000} +: 8];
  end

  // Read-first: the array update above is non-blocking, so a same-cycle
  // write is not yet visible here.
  always_ff @(posedge clk) begin
    if (reset)     rd_q <= '0;
    else if (rden) rd_q <= p_in_range ? mem[p_idx] : '0;
  end

  assign readData   = rd_q;
  assign host_rdata = rdata_q;

endmodule
